// File: rtl/caf_feeder_pkg.sv
// Shared definitions for the CAF dot-product feeder: FSM state encoding.
// Pure declarations, no logic, so there is no latency or backpressure to describe.
package caf_feeder_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/dot_prod_feeder_sample_buffer.sv
// Single write port sample store with asynchronous read; a write lands at the clock edge.
// Out-of-range write addresses are discarded; reads are combinational and never stall.
module sample_buffer #(
  parameter int depth     = 5,
  parameter int addr_bits = 3,
  parameter int width     = 24
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [addr_bits-1:0] wr_addr,
  input  logic [width-1:0]     wr_dat,
  input  logic [addr_bits-1:0] rd_addr,
  output logic [width-1:0]     rd_dat
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < depth)) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/dot_prod_feeder.sv
// Streams (ref[n], rx[n+k]) pairs for every lag k; first beat valid one cycle after start.
// Ready low holds data, lag and counters; buffers are write-locked while a run is active.
module dot_prod_feeder
  import caf_feeder_pkg::*;
#(
  parameter int i_bits              = 12,
  parameter int q_bits              = 12,
  parameter int length              = 5,
  parameter int length_counter_size = 3,
  parameter int num_lags            = 3,
  parameter int lag_counter_size    = 2,
  parameter int buffer_length       = 7,
  parameter int buffer_addr_size    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ref_wr_en,
  input  logic [buffer_addr_size-1:0] ref_wr_addr,
  input  logic [i_bits-1:0]           ref_wr_i,
  input  logic [q_bits-1:0]           ref_wr_q,
  input  logic                        rx_wr_en,
  input  logic [buffer_addr_size-1:0] rx_wr_addr,
  input  logic [i_bits-1:0]           rx_wr_i,
  input  logic [q_bits-1:0]           rx_wr_q,
  input  logic                        start,
  input  logic                        m_axis_data_tready,
  output logic                        s_axis_x_tvalid,
  output logic [i_bits-1:0]           xi,
  output logic [q_bits-1:0]           xq,
  output logic                        s_axis_y_tvalid,
  output logic [i_bits-1:0]           yi,
  output logic [q_bits-1:0]           yq,
  output logic [lag_counter_size-1:0] lag,
  output logic                        busy,
  output logic                        done
);

  localparam logic [length_counter_size-1:0] n_last = length_counter_size'(length - 1);
  localparam logic [lag_counter_size-1:0]    k_last = lag_counter_size'(num_lags - 1);

  logic [1:0]                        state, state_nxt;
  logic [length_counter_size-1:0]    n, n_nxt;
  logic [lag_counter_size-1:0]       k, k_nxt;
  logic                              load;
  logic                              wr_open;
  logic [buffer_addr_size-1:0]       ref_rd_addr, rx_rd_addr;
  logic [i_bits+q_bits-1:0]          ref_rd_dat, rx_rd_dat;

  // Buffers only take writes between runs so a stream sees one consistent snapshot.
  assign wr_open = (state == ST_IDLE);

  // Read addresses follow the next counter values so the output registers load in the same edge.
  assign ref_rd_addr = buffer_addr_size'(n_nxt);
  assign rx_rd_addr  = buffer_addr_size'(n_nxt) + buffer_addr_size'(k_nxt);

  sample_buffer #(.depth(length), .addr_bits(buffer_addr_size), .width(i_bits + q_bits)) u_ref_buf (
    .clk     (clk),
    .wr_en   (ref_wr_en && wr_open),
    .wr_addr (ref_wr_addr),
    .wr_dat  ({ref_wr_i, ref_wr_q}),
    .rd_addr (ref_rd_addr),
    .rd_dat  (ref_rd_dat)
  );

  sample_buffer #(.depth(buffer_length), .addr_bits(buffer_addr_size), .width(i_bits + q_bits)) u_rx_buf (
    .clk     (clk),
    .wr_en   (rx_wr_en && wr_open),
    .wr_addr (rx_wr_addr),
    .wr_dat  ({rx_wr_i, rx_wr_q}),
    .rd_addr (rx_rd_addr),
    .rd_dat  (rx_rd_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      n     <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      n     <= n_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    k_nxt     = k;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_STREAM;
          n_nxt     = '0;
          k_nxt     = '0;
          load      = 1'b1;
        end
      end
      ST_STREAM: begin
        if (m_axis_data_tready) begin
          if (n == n_last) begin
            n_nxt = '0;
            // Final pair of the final lag: park the counters and let valid drop.
            if (k == k_last) begin
              state_nxt = ST_DONE;
              k_nxt     = '0;
            end else begin
              k_nxt = k + 1'b1;
              load  = 1'b1;
            end
          end else begin
            n_nxt = n + 1'b1;
            load  = 1'b1;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_x_tvalid = (state == ST_STREAM);
    s_axis_y_tvalid = (state == ST_STREAM);
    busy            = (state == ST_STREAM);
    done            = (state == ST_DONE);
  end

  assign lag = k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xi <= '0;
      xq <= '0;
      yi <= '0;
      yq <= '0;
    end else if (load) begin
      {xi, xq} <= ref_rd_dat;
      {yi, yq} <= rx_rd_dat;
    end
  end

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Scoreboard bench: stimulus pushes expected beats from an array model of ref/rx,
// a negedge monitor pops and compares them and a per-lag dot-product sum.
module tb_dot_prod_feeder;

  localparam int IB = 12, QB = 12, LEN = 5, LCS = 3, NL = 3, LGS = 2, BL = 7, BAS = 3;

  typedef struct {
    logic [IB-1:0]  xi;
    logic [QB-1:0]  xq;
    logic [IB-1:0]  yi;
    logic [QB-1:0]  yq;
    logic [LGS-1:0] lag;
    bit             last_of_lag;
    longint         sum_i;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ref_wr_en = 1'b0, rx_wr_en = 1'b0, start = 1'b0;
  logic [BAS-1:0] ref_wr_addr = '0, rx_wr_addr = '0;
  logic [IB-1:0] ref_wr_i = '0, rx_wr_i = '0;
  logic [QB-1:0] ref_wr_q = '0, rx_wr_q = '0;
  logic m_axis_data_tready = 1'b1;
  logic s_axis_x_tvalid, s_axis_y_tvalid, busy, done;
  logic [IB-1:0] xi, yi;
  logic [QB-1:0] xq, yq;
  logic [LGS-1:0] lag;

  logic signed [IB-1:0] ref_i_m [LEN];
  logic signed [QB-1:0] ref_q_m [LEN];
  logic signed [IB-1:0] rx_i_m [BL];
  logic signed [QB-1:0] rx_q_m [BL];

  beat_t  exp_q[$];
  int     checks = 0;
  int     fails = 0;
  int     beats = 0;
  int     runs_done = 0;
  int     rdy_mode = 0;
  int     ph = 0;
  logic [3:0] rdy_pat = 4'b1001;
  longint acc = 0;
  bit     last_flag = 0;
  int     cyc;

  dot_prod_feeder #(
    .i_bits(IB), .q_bits(QB), .length(LEN), .length_counter_size(LCS),
    .num_lags(NL), .lag_counter_size(LGS), .buffer_length(BL), .buffer_addr_size(BAS)
  ) dut (
    .clk(clk), .rst(rst),
    .ref_wr_en(ref_wr_en), .ref_wr_addr(ref_wr_addr), .ref_wr_i(ref_wr_i), .ref_wr_q(ref_wr_q),
    .rx_wr_en(rx_wr_en), .rx_wr_addr(rx_wr_addr), .rx_wr_i(rx_wr_i), .rx_wr_q(rx_wr_q),
    .start(start), .m_axis_data_tready(m_axis_data_tready),
    .s_axis_x_tvalid(s_axis_x_tvalid), .xi(xi), .xq(xq),
    .s_axis_y_tvalid(s_axis_y_tvalid), .yi(yi), .yq(yq),
    .lag(lag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready pattern per cycle: held high, 1-0-0-1 repeating, or random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: begin
        m_axis_data_tready = rdy_pat[ph];
        ph = (ph + 1) % 4;
      end
      2: m_axis_data_tready = 1'($urandom_range(0, 1));
      default: m_axis_data_tready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      acc = 0;
      last_flag = 0;
    end else begin
      check("y_vld_eq_x_vld", 64'(s_axis_y_tvalid), 64'(s_axis_x_tvalid));
      if (last_flag) begin
        check("done_pulse", 64'(done), 64'd1);
        check("busy_fall", 64'(busy), 64'd0);
        last_flag = 0;
        runs_done++;
      end else begin
        check("no_spurious_done", 64'(done), 64'd0);
      end
      if (exp_q.size() == 0) begin
        check("no_extra_beat", 64'(s_axis_x_tvalid), 64'd0);
      end else if (s_axis_x_tvalid) begin
        b = exp_q[0];
        check("beat", 64'({xi, xq, yi, yq, lag}), 64'({b.xi, b.xq, b.yi, b.yq, b.lag}));
        if (m_axis_data_tready) begin
          void'(exp_q.pop_front());
          beats++;
          acc += longint'($signed(xi)) * longint'($signed(yi));
          if (b.last_of_lag) begin
            check("lag_sum_i", 64'(acc), 64'(b.sum_i));
            acc = 0;
          end
          if (exp_q.size() == 0) last_flag = 1;
        end
      end
    end
  end

  task automatic push_run();
    beat_t  b;
    longint s;
    for (int k = 0; k < NL; k++) begin
      s = 0;
      for (int n = 0; n < LEN; n++) begin
        s += longint'(ref_i_m[n]) * longint'(rx_i_m[n + k]);
        b.xi = ref_i_m[n];
        b.xq = ref_q_m[n];
        b.yi = rx_i_m[n + k];
        b.yq = rx_q_m[n + k];
        b.lag = LGS'(k);
        b.last_of_lag = (n == LEN - 1);
        b.sum_i = s;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic wr_ref(input int a, input int vi, input int vq, input bit upd);
    ref_wr_en = 1'b1; ref_wr_addr = BAS'(a); ref_wr_i = IB'(vi); ref_wr_q = QB'(vq);
    @(posedge clk); #1;
    ref_wr_en = 1'b0;
    if (upd && a < LEN) begin
      ref_i_m[a] = IB'(vi);
      ref_q_m[a] = QB'(vq);
    end
  endtask

  task automatic wr_rx(input int a, input int vi, input int vq, input bit upd);
    rx_wr_en = 1'b1; rx_wr_addr = BAS'(a); rx_wr_i = IB'(vi); rx_wr_q = QB'(vq);
    @(posedge clk); #1;
    rx_wr_en = 1'b0;
    if (upd && a < BL) begin
      rx_i_m[a] = IB'(vi);
      rx_q_m[a] = QB'(vq);
    end
  endtask

  task automatic fill_basic();
    for (int n = 0; n < LEN; n++) wr_ref(n, n + 1, 0, 1'b1);
    for (int m = 0; m < BL; m++) wr_rx(m, 10 * m, 0, 1'b1);
    wr_ref(5, 777, 777, 1'b1);
    wr_rx(7, 777, 777, 1'b1);
  endtask

  task automatic start_run();
    push_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_vld", 64'(s_axis_x_tvalid), 64'd1);
  endtask

  task automatic wait_done(output int c);
    int r0;
    r0 = runs_done;
    c = 0;
    while (runs_done == r0 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("run_completes", 64'(runs_done - r0), 64'd1);
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({s_axis_x_tvalid, s_axis_y_tvalid, busy, done}), 64'd0);
    check("reset_data", 64'({xi, xq, yi, yq, lag}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic stream with ready high, including the throughput/done timing.
    fill_basic();
    start_run();
    wait_done(cyc);
    check("throughput_cycles", 64'(cyc), 64'(LEN * NL + 1));

    // Backpressure 1,0,0,1.
    rdy_mode = 1;
    start_run();
    wait_done(cyc);
    rdy_mode = 0;

    // Lock-out: write and start during a run are ignored; a later write is seen.
    start_run();
    repeat (4) @(posedge clk);
    #1;
    rx_wr_en = 1'b1; rx_wr_addr = 3'd3; rx_wr_i = 12'd999; rx_wr_q = 12'd999; start = 1'b1;
    @(posedge clk); #1;
    rx_wr_en = 1'b0; start = 1'b0;
    wait_done(cyc);
    wr_rx(3, 999, 0, 1'b1);
    start_run();
    wait_done(cyc);

    // Reset after the 7th transfer.
    beats = 0;
    start_run();
    for (int c = 0; c < 200 && beats < 7; c++) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrun_rst_ctrl", 64'({s_axis_x_tvalid, s_axis_y_tvalid, busy, done}), 64'd0);
    check("midrun_rst_data", 64'({xi, xq, yi, yq, lag}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start_run();
    wait_done(cyc);

    // Signed extremes.
    for (int n = 0; n < LEN; n++) wr_ref(n, -2048, -2048, 1'b1);
    for (int m = 0; m < BL; m++) wr_rx(m, 2047, 2047, 1'b1);
    start_run();
    wait_done(cyc);

    // Random data under random backpressure.
    rdy_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < LEN; n++) wr_ref(n, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 1'b1);
      for (int m = 0; m < BL; m++) wr_rx(m, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 1'b1);
      start_run();
      wait_done(cyc);
    end
    rdy_mode = 0;

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dot_prod_feeder.md
# dot_prod_feeder

Source-side driver for the pipelined dot-product stage in the CAF datapath. The block holds a reference vector and a received-sample buffer. On `start` it streams, for every lag k in 0..num_lags-1, the `length` aligned pairs (ref[n], rx[n+k]) into the dot product's x/y inputs under a valid/ready handshake. The dot product closes each sum with its own length counter, so this block emits exactly `length` pairs per lag, with no gaps and no extra beats.

## Interface
Parameters:
- `i_bits`, 12: in-phase sample width, shared by ref and rx.
- `q_bits`, 12: quadrature sample width.
- `length`, 5: dot-product length N.
- `length_counter_size`, 3: counter width; must satisfy 2^length_counter_size ≥ length.
- `num_lags`, 3: number of lags streamed per run.
- `lag_counter_size`, 2: counter width; must satisfy 2^lag_counter_size ≥ num_lags.
- `buffer_length`, 7: rx depth; must equal length + num_lags − 1.
- `buffer_addr_size`, 3: address width; must satisfy 2^buffer_addr_size ≥ buffer_length.

Ports (widths use the parameter names above):
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `ref_wr_en`, in, 1: reference write strobe.
- `ref_wr_addr`, in, buffer_addr_size: reference address; valid range 0..length-1.
- `ref_wr_i` / `ref_wr_q`, in, i_bits / q_bits: reference sample.
- `rx_wr_en`, in, 1: rx write strobe.
- `rx_wr_addr`, in, buffer_addr_size: rx address; valid range 0..buffer_length-1.
- `rx_wr_i` / `rx_wr_q`, in, i_bits / q_bits: rx sample.
- `start`, in, 1: single-cycle request to begin a run.
- `m_axis_data_tready`, in, 1: downstream ready.
- `s_axis_x_tvalid`, out, 1: x beat valid.
- `xi` / `xq`, out, i_bits / q_bits: reference sample ref[n].
- `s_axis_y_tvalid`, out, 1: y beat valid; always equal to `s_axis_x_tvalid`.
- `yi` / `yq`, out, i_bits / q_bits: rx sample rx[n+k].
- `lag`, out, lag_counter_size: lag k of the presented beat.
- `busy`, out, 1: high from the accepted `start` through the last transfer.
- `done`, out, 1: one-cycle pulse after the last transfer.

## Operation
State machine, states IDLE, STREAM, DONE:
- **IDLE.**
  - Buffer writes are accepted.
  - `start` moves to STREAM with n=0, k=0; ref[0] and rx[0] are loaded into the output registers and valid is raised.
- **STREAM.** A transfer occurs when valid && `m_axis_data_tready`.
  - On each transfer: n=n+1. When n==length-1, n wraps to 0 and k=k+1.
  - The output registers then load ref[n'] and rx[n'+k'] in the same cycle.
  - On the transfer with n==length-1 and k==num_lags-1: valid drops and the state moves to DONE.
  - With ready low, all outputs and counters hold.
- **DONE.** `done`=1 for one cycle, then IDLE.
- **Writes while busy** (STREAM or DONE) are dropped; buffer contents are frozen for the whole run.
- **Ignored `start`:** `start` in STREAM or DONE is ignored.
- **Out-of-range write addresses:** writes with ref addr ≥ length or rx addr ≥ buffer_length are dropped.
- **Samples** pass through unmodified; there is no arithmetic on data.

## Timing
- **Reset values:** valids 0, `busy` 0, `done` 0, `lag` 0, `xi`/`xq`/`yi`/`yq` 0, state IDLE, counters 0. Buffer arrays are not reset.
- **Reset mid-run:** return to IDLE immediately (asynchronously); valids drop; no `done` pulse.
- **Start latency:** `start` sampled at edge t gives valid=1 and `busy`=1 after edge t.
- **Write timing:** a write at edge t is visible to a `start` sampled at edge t+1.
- **Throughput:** with ready held high, one beat per cycle and no bubble at lag boundaries. The last transfer occurs length×num_lags cycles after the start edge.
- **Done timing:** `done` is high in the cycle after the last transfer; `busy` falls in that same cycle.
- **Stability under backpressure:** while valid && !ready, data and `lag` are stable.

## Structure
- **Package `caf_feeder_pkg`:** state encoding localparams (IDLE=0, STREAM=1, DONE=2).
- **Sub-module `sample_buffer`:** one write port, asynchronous read, parameterised depth and width. Instantiated twice: ref (depth `length`) and rx (depth `buffer_length`).
- **Top level:** holds the FSM, the n/k counters, and the rx address adder n+k.

## Test plan
Defaults throughout: length=5, num_lags=3.
1. **Basic stream.** Fill ref[n]=n+1 (q=0) and rx[m]=10m; ready held high; pulse `start`.
   - 15 beats, lags 0,0,0,0,0,1,…,2.
   - y sequence 0,10,20,30,40 | 10…50 | 20…60.
   - `done` one cycle after the 15th beat.
2. **Backpressure.** Same data; toggle ready 1,0,0,1 repeating.
   - Identical beat sequence.
   - Outputs stable during ready=0.
   - No duplicated or skipped pair.
3. **Lock-out.** Issue an rx write of 999 at address 3 and a second `start` mid-run.
   - Both ignored; stream still shows rx[3]=30.
   - A post-`done` write of 999 to rx[3] is reflected in the next run.
4. **Reset mid-run.** Assert `rst` at beat 7.
   - Valid, `busy` and outputs go to 0 immediately; no `done` pulse.
   - A new `start` restarts from lag 0, n=0.
5. **Signed extremes.** ref=−2048 (i_bits=12) and rx=2047 everywhere.
   - Values pass through bit-exact.
   - A downstream dot-product model gives sum_i=5×(−2048×2047) per lag.
